// File: rtl/mach_tao_xung_pkg.sv
// ----------------------------------------------------------------------------
// mach_tao_xung_pkg : shared state encoding and widths for the pulse-train
// controller family.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

package mach_tao_xung_pkg;

    localparam int W_DEF = 31;
    localparam int CNT_W = 16;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_DONE = 2'd2
    } state_t;

endpackage

`default_nettype wire

// File: rtl/dieu_khien_xung_bo_dem_pha.sv
// ----------------------------------------------------------------------------
// bo_dem_pha : W-bit divide-by-(P+1) phase counter with clear, enable and
// terminal-count flag.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module bo_dem_pha
    import mach_tao_xung_pkg::*;
#(
    parameter int W = W_DEF
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr_i,
    input  logic         en_i,
    input  logic [W-1:0] period_i,
    output logic [W-1:0] r_o,
    output logic         tc_o
);

    logic [W-1:0] r_q;

    assign tc_o = (r_q == period_i);
    assign r_o  = r_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q <= '0;
        end else if (clr_i) begin
            r_q <= '0;
        end else if (en_i) begin
            r_q <= tc_o ? '0 : r_q + 1'b1;
        end
    end

endmodule

`default_nettype wire

// File: rtl/dieu_khien_xung.sv
// ----------------------------------------------------------------------------
// dieu_khien_xung : programmable pulse-train controller with burst/continuous
// runs, graceful stop and period-boundary reconfiguration.  Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module dieu_khien_xung
    import mach_tao_xung_pkg::*;
#(
    parameter int          W     = W_DEF,
    parameter int unsigned P_DEF = 50000000,
    parameter int unsigned H_DEF = 25000000
) (
    input  logic             clki,
    input  logic             rst_n,
    input  logic             cfg_valid,
    output logic             cfg_ready,
    input  logic [W-1:0]     cfg_period,
    input  logic [W-1:0]     cfg_high,
    input  logic [CNT_W-1:0] cfg_count,
    input  logic             start,
    input  logic             stop,
    output logic             clko,
    output logic             tick,
    output logic             busy,
    output logic             done
);

    state_t           state_q;
    logic [W-1:0]     act_p_q, act_h_q, sh_p_q, sh_h_q;
    logic [CNT_W-1:0] act_cnt_q, sh_cnt_q, pcnt_q;
    logic             sh_valid_q, stop_pend_q;

    logic [W-1:0]     r_q;
    logic             tc;
    logic             running, accept, tick_d, apply_d, burst_end_d, finish_d;

    assign running     = (state_q == S_RUN);
    assign accept      = cfg_valid & ~sh_valid_q;
    assign tick_d      = running & tc;
    assign apply_d     = tick_d & sh_valid_q;
    assign burst_end_d = tick_d & (act_cnt_q != '0) & (pcnt_q == act_cnt_q - 16'd1);
    assign finish_d    = burst_end_d | (tick_d & stop_pend_q);

    // Counter is frozen at zero outside RUN and restarts when a shadow lands.
    bo_dem_pha #(.W(W)) u_bo_dem_pha (
        .clk      (clki),
        .rst_n    (rst_n),
        .clr_i    (~running | apply_d),
        .en_i     (running),
        .period_i (act_p_q),
        .r_o      (r_q),
        .tc_o     (tc)
    );

    always_ff @(posedge clki) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            act_p_q     <= W'(P_DEF);
            act_h_q     <= W'(H_DEF);
            act_cnt_q   <= '0;
            sh_p_q      <= '0;
            sh_h_q      <= '0;
            sh_cnt_q    <= '0;
            sh_valid_q  <= 1'b0;
            stop_pend_q <= 1'b0;
            pcnt_q      <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_RUN;
                        pcnt_q      <= '0;
                        stop_pend_q <= 1'b0;
                    end
                end
                S_RUN: begin
                    if (stop)
                        stop_pend_q <= 1'b1;
                    if (tick_d)
                        pcnt_q <= pcnt_q + 16'd1;
                    if (finish_d) begin
                        state_q     <= S_DONE;
                        stop_pend_q <= 1'b0;
                    end
                    if (apply_d)
                        pcnt_q <= '0;
                end
                S_DONE:  state_q <= S_IDLE;
                default: state_q <= S_IDLE;
            endcase

            if (accept) begin
                if (running) begin
                    sh_p_q     <= cfg_period;
                    sh_h_q     <= cfg_high;
                    sh_cnt_q   <= cfg_count;
                    sh_valid_q <= 1'b1;
                end else begin
                    act_p_q   <= cfg_period;
                    act_h_q   <= cfg_high;
                    act_cnt_q <= cfg_count;
                end
            end

            if (apply_d) begin
                act_p_q    <= sh_p_q;
                act_h_q    <= sh_h_q;
                act_cnt_q  <= sh_cnt_q;
                sh_valid_q <= 1'b0;
            end
        end
    end

    assign clko      = running & (r_q < act_h_q);
    assign tick      = tick_d;
    assign busy      = running;
    assign done      = (state_q == S_DONE);
    assign cfg_ready = ~sh_valid_q;

endmodule

`default_nettype wire

// File: tb/tb_dieu_khien_xung.sv
// ----------------------------------------------------------------------------
// tb_dieu_khien_xung : directed self-checking bench for dieu_khien_xung.
// Rev 1.0
// ----------------------------------------------------------------------------
`default_nettype none

module tb_dieu_khien_xung;

    logic        clki;
    logic        rst_n;
    logic        cfg_valid;
    logic        cfg_ready;
    logic [30:0] cfg_period;
    logic [30:0] cfg_high;
    logic [15:0] cfg_count;
    logic        start;
    logic        stop;
    logic        clko;
    logic        tick;
    logic        busy;
    logic        done;

    int total;
    int bad;

    dieu_khien_xung dut (
        .clki       (clki),
        .rst_n      (rst_n),
        .cfg_valid  (cfg_valid),
        .cfg_ready  (cfg_ready),
        .cfg_period (cfg_period),
        .cfg_high   (cfg_high),
        .cfg_count  (cfg_count),
        .start      (start),
        .stop       (stop),
        .clko       (clko),
        .tick       (tick),
        .busy       (busy),
        .done       (done)
    );

    initial begin
        clki = 1'b0;
        forever #5 clki = ~clki;
    end

    // Observed vector order: {clko, tick, busy, done, cfg_ready}
    task automatic do_reset();
        rst_n     = 1'b0;
        cfg_valid = 1'b0;
        start     = 1'b0;
        stop      = 1'b0;
        repeat (2) @(negedge clki);
        rst_n = 1'b1;
    endtask

    task automatic launch(input int p, input int h, input int c);
        cfg_valid  = 1'b1;
        cfg_period = 31'(p);
        cfg_high   = 31'(h);
        cfg_count  = 16'(c);
        start      = 1'b1;
        @(negedge clki);
        cfg_valid = 1'b0;
        start     = 1'b0;
    endtask

    task automatic test_reset();
        logic [4:0] exp;
        rst_n = 1'b0; stop = 1'b0;
        cfg_valid = 1'b1; cfg_period = 31'd4; cfg_high = 31'd2; cfg_count = 16'd0;
        start = 1'b1;
        for (int i = 0; i < 20; i++) begin
            @(negedge clki);
            total++;
            if ({clko, tick, busy, done, cfg_ready} !== 5'b00001) begin
                bad++;
                $display("FAIL reset_out cyc%0d: got %b want 00001", i, {clko, tick, busy, done, cfg_ready});
            end
        end
        rst_n = 1'b1;
        @(negedge clki);
        cfg_valid = 1'b0; start = 1'b0;
        for (int i = 0; i < 15; i++) begin
            exp = {(i % 5) < 2, (i % 5) == 4, 1'b1, 1'b0, 1'b1};
            total++;
            if ({clko, tick, busy, done, cfg_ready} !== exp) begin
                bad++;
                $display("FAIL reset_run cyc%0d: got %b want %b", i, {clko, tick, busy, done, cfg_ready}, exp);
            end
            @(negedge clki);
        end
    endtask

    task automatic test_burst();
        logic [4:0] exp;
        int ticks;
        ticks = 0;
        do_reset();
        launch(3, 1, 3);
        for (int i = 0; i < 14; i++) begin
            if (i < 12)       exp = {(i % 4) == 0, (i % 4) == 3, 1'b1, 1'b0, 1'b1};
            else if (i == 12) exp = 5'b00011;
            else              exp = 5'b00001;
            if (tick === 1'b1) ticks++;
            total++;
            if ({clko, tick, busy, done, cfg_ready} !== exp) begin
                bad++;
                $display("FAIL burst cyc%0d: got %b want %b", i, {clko, tick, busy, done, cfg_ready}, exp);
            end
            @(negedge clki);
        end
        total++;
        if (ticks != 3) begin
            bad++;
            $display("FAIL burst_ticks: got %0d want 3", ticks);
        end
    endtask

    task automatic test_stop();
        logic [4:0] exp;
        do_reset();
        launch(9, 5, 0);
        for (int i = 0; i < 12; i++) begin
            if (i < 10)       exp = {i < 5, i == 9, 1'b1, 1'b0, 1'b1};
            else if (i == 10) exp = 5'b00011;
            else              exp = 5'b00001;
            total++;
            if ({clko, tick, busy, done, cfg_ready} !== exp) begin
                bad++;
                $display("FAIL stop cyc%0d: got %b want %b", i, {clko, tick, busy, done, cfg_ready}, exp);
            end
            stop = (i == 2);
            @(negedge clki);
        end
        stop = 1'b0;
    endtask

    task automatic test_reconfig();
        logic [4:0] exp;
        int j;
        do_reset();
        launch(7, 4, 0);
        for (int i = 0; i < 16; i++) begin
            if (i < 8) begin
                exp = {i < 4, i == 7, 1'b1, 1'b0, i < 2};
            end else begin
                j = (i - 8) % 4;
                exp = {j < 3, j == 3, 1'b1, 1'b0, 1'b1};
            end
            total++;
            if ({clko, tick, busy, done, cfg_ready} !== exp) begin
                bad++;
                $display("FAIL reconfig cyc%0d: got %b want %b", i, {clko, tick, busy, done, cfg_ready}, exp);
            end
            if (i == 1) begin
                cfg_valid = 1'b1; cfg_period = 31'd3; cfg_high = 31'd3; cfg_count = 16'd0;
            end else if (i == 2) begin
                cfg_period = 31'd1; cfg_high = 31'd0;
            end else if (i == 4) begin
                cfg_valid = 1'b0;
            end
            @(negedge clki);
        end
    endtask

    task automatic test_edges();
        logic [4:0] exp;
        do_reset();
        launch(0, 1, 0);
        for (int i = 0; i < 6; i++) begin
            total++;
            if ({clko, tick, busy, done, cfg_ready} !== 5'b11101) begin
                bad++;
                $display("FAIL edge_p0 cyc%0d: got %b want 11101", i, {clko, tick, busy, done, cfg_ready});
            end
            @(negedge clki);
        end
        do_reset();
        launch(5, 0, 0);
        for (int i = 0; i < 12; i++) begin
            exp = {1'b0, (i % 6) == 5, 1'b1, 1'b0, 1'b1};
            total++;
            if ({clko, tick, busy, done, cfg_ready} !== exp) begin
                bad++;
                $display("FAIL edge_h0 cyc%0d: got %b want %b", i, {clko, tick, busy, done, cfg_ready}, exp);
            end
            @(negedge clki);
        end
        do_reset();
        launch(5, 9, 0);
        for (int i = 0; i < 12; i++) begin
            exp = {1'b1, (i % 6) == 5, 1'b1, 1'b0, 1'b1};
            total++;
            if ({clko, tick, busy, done, cfg_ready} !== exp) begin
                bad++;
                $display("FAIL edge_hbig cyc%0d: got %b want %b", i, {clko, tick, busy, done, cfg_ready}, exp);
            end
            @(negedge clki);
        end
    endtask

    task automatic test_back_to_back();
        logic [4:0] exp;
        int dones;
        dones = 0;
        do_reset();
        launch(2, 1, 2);
        for (int i = 0; i < 10; i++) begin
            if (i < 6)       exp = {(i % 3) == 0, (i % 3) == 2, 1'b1, 1'b0, 1'b1};
            else if (i == 6) exp = 5'b00011;
            else             exp = 5'b00001;
            if (done === 1'b1) dones++;
            total++;
            if ({clko, tick, busy, done, cfg_ready} !== exp) begin
                bad++;
                $display("FAIL simul cyc%0d: got %b want %b", i, {clko, tick, busy, done, cfg_ready}, exp);
            end
            stop = (i == 4);
            @(negedge clki);
        end
        stop = 1'b0;
        total++;
        if (dones != 1) begin
            bad++;
            $display("FAIL simul_dones: got %0d want 1", dones);
        end
    endtask

    task automatic test_reset_mid();
        logic [4:0] exp;
        do_reset();
        launch(9, 5, 0);
        for (int i = 0; i < 3; i++) begin
            exp = {1'b1, 1'b0, 1'b1, 1'b0, 1'b1};
            total++;
            if ({clko, tick, busy, done, cfg_ready} !== exp) begin
                bad++;
                $display("FAIL rstmid_run cyc%0d: got %b want %b", i, {clko, tick, busy, done, cfg_ready}, exp);
            end
            @(negedge clki);
        end
        rst_n = 1'b0;
        @(negedge clki);
        rst_n = 1'b1;
        for (int i = 0; i < 4; i++) begin
            total++;
            if ({clko, tick, busy, done, cfg_ready} !== 5'b00001) begin
                bad++;
                $display("FAIL rstmid_after cyc%0d: got %b want 00001", i, {clko, tick, busy, done, cfg_ready});
            end
            @(negedge clki);
        end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst_n = 1'b0;
        cfg_valid = 1'b0; cfg_period = '0; cfg_high = '0; cfg_count = '0;
        start = 1'b0; stop = 1'b0;
        test_reset();
        test_burst();
        test_stop();
        test_reconfig();
        test_edges();
        test_back_to_back();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

`default_nettype wire
